// File: rtl/rv_iommu_fq_wr_master_if.sv
// AXI request/response bundle between the fault-queue write master and the
// FQ port of the data-structures bus interface. Only the channels the write
// master drives or observes are carried.
interface rv_iommu_fq_wr_master_if;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic        user;
  } axi_aw_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } axi_b_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
  } axi_rsp_t;

  axi_req_t mem_req;
  axi_rsp_t mem_resp;

  modport master (output mem_req, input mem_resp);
  modport slave  (input mem_req, output mem_resp);

endinterface

// File: rtl/rv_iommu_fq_wr_master.sv
// IOMMU fault-queue AXI write master. Takes one 32-byte fault record, writes
// it as a single 4-beat INCR burst of 8-byte beats, waits for the write
// response and reports completion plus bus/alignment error status.
// Every bus output is decoded from registered state only, so there is no
// combinational path from the response channel back to any valid.
module rv_iommu_fq_wr_master #(
  parameter logic [3:0] AXI_ID = 4'b0001
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [63:0]                    req_addr_i,
  input  logic [255:0]                   req_data_i,
  output logic                           done_o,
  output logic                           error_o,
  output logic                           busy_o,
  rv_iommu_fq_wr_master_if.master        mem
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic [63:0]   addr_q, addr_d;
  logic [255:0]  data_q, data_d;

  // The B channel id/user fields carry nothing this block needs.
  logic unused_b;
  assign unused_b = ^{mem.mem_resp.b.id, mem.mem_resp.b.user};

  // Control state register; reset abandons any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  // Record payload holding register; only meaningful while a burst is active.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Next-state logic: accept, address phase, four data beats, response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d = req_addr_i;
          data_d = req_data_i;
          cnt_d  = 2'd0;
          // A misaligned record would straddle the 32-byte slot; reject it
          // without touching the bus.
          if (req_addr_i[4:0] != 5'd0) begin
            flag_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            flag_d  = 1'b0;
            state_d = S_AW;
          end
        end
      end
      S_AW: begin
        if (mem.mem_resp.aw_ready) begin
          state_d = S_W;
        end
      end
      S_W: begin
        if (mem.mem_resp.w_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_B;
          end
        end
      end
      S_B: begin
        if (mem.mem_resp.b_valid) begin
          // SLVERR (2'b10) and DECERR (2'b11) both have resp[1] set.
          flag_d  = mem.mem_resp.b.resp[1];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // AXI request decode; W is only raised after the AW handshake so the
  // interface has already queued the routing ID when data arrives.
  always_comb begin
    mem.mem_req          = '0;
    mem.mem_req.aw.id    = AXI_ID;
    mem.mem_req.aw.addr  = addr_q;
    mem.mem_req.aw.len   = 8'd3;
    mem.mem_req.aw.size  = 3'd3;
    mem.mem_req.aw.burst = 2'b01;
    mem.mem_req.aw_valid = (state_q == S_AW);
    mem.mem_req.w.data   = data_q[{cnt_q, 6'b0} +: 64];
    mem.mem_req.w.strb   = 8'hFF;
    mem.mem_req.w.last   = (cnt_q == 2'd3);
    mem.mem_req.w_valid  = (state_q == S_W);
    mem.mem_req.b_ready  = (state_q == S_B);
    mem.mem_req.ar_valid = 1'b0;
    mem.mem_req.r_ready  = 1'b0;
  end

  // Handler-side status decode.
  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    error_o     = (state_q == S_DONE) && flag_q;
  end

endmodule

// File: tb/tb_rv_iommu_fq_wr_master.sv
// Bench for the fault-queue write master: a table of records driven through a
// reactive AXI slave model, hand sequences for stalls and mid-burst reset,
// and a randomised back-pressure regression checked by a scoreboard.
module tb_rv_iommu_fq_wr_master;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready, done, error, busy;
  logic [63:0]  req_addr = '0;
  logic [255:0] req_data = '0;

  rv_iommu_fq_wr_master_if bus ();

  rv_iommu_fq_wr_master #(.AXI_ID(4'b0001)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .done_o      (done),
    .error_o     (error),
    .busy_o      (busy),
    .mem         (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0]  addr;
    logic [255:0] data;
  } rec_t;

  rec_t sb[$];

  // Slave model configuration: 0 = all ready, 1 = AW held 5 cycles and W
  // toggling ready, 2 = random back-pressure.
  int         mode = 0;
  logic [1:0] b_resp_cfg = 2'b00;

  // Slave model / monitor state
  bit          aw_seen;
  int          outstanding;
  int          beat;
  logic [255:0] cap;
  bit          b_pend;
  int          aw_wait;
  bit          w_tog;
  bit          aw_stall_prev, w_stall_prev;
  logic [80:0] aw_prev;
  logic [72:0] w_prev;

  always @(negedge clk) begin
    logic        awr, wr, bv;
    logic [80:0] aw_cur;
    logic [72:0] w_cur;
    rec_t        e;
    if (rst) begin
      aw_seen = 0; outstanding = 0; beat = 0; b_pend = 0; aw_wait = 0;
      w_tog = 1; aw_stall_prev = 0; w_stall_prev = 0;
      sb.delete();
      bus.mem_resp.aw_ready = 1'b0;
      bus.mem_resp.w_ready  = 1'b0;
      bus.mem_resp.b_valid  = 1'b0;
      bus.mem_resp.b        = '0;
    end else begin
      check("ar_r_never", {bus.mem_req.ar_valid, bus.mem_req.r_ready}, 0);
      case (mode)
        0: begin awr = 1'b1; wr = 1'b1; end
        1: begin awr = (aw_wait >= 5); wr = w_tog; end
        default: begin awr = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1)); end
      endcase
      bv = b_pend && (mode != 2 || $urandom_range(0, 2) != 0);
      bus.mem_resp.aw_ready = awr;
      bus.mem_resp.w_ready  = wr;
      bus.mem_resp.b_valid  = bv;
      bus.mem_resp.b.resp   = b_resp_cfg;
      bus.mem_resp.b.id     = 4'b0001;
      bus.mem_resp.b.user   = 1'b0;

      aw_cur = {bus.mem_req.aw.addr, bus.mem_req.aw.len, bus.mem_req.aw.size,
                bus.mem_req.aw.burst, bus.mem_req.aw.id};
      if (bus.mem_req.aw_valid) begin
        if (aw_stall_prev) check("aw_stable", aw_cur, aw_prev);
        aw_prev = aw_cur;
        aw_stall_prev = !awr;
        if (awr) begin
          check("aw_outstanding", outstanding, 0);
          check("aw_expected", sb.size(), 1);
          if (sb.size() > 0) check("aw_addr", bus.mem_req.aw.addr, sb[0].addr);
          check("aw_id", bus.mem_req.aw.id, 4'b0001);
          check("aw_len", bus.mem_req.aw.len, 8'd3);
          check("aw_size", bus.mem_req.aw.size, 3'd3);
          check("aw_burst", bus.mem_req.aw.burst, 2'b01);
          check("aw_misc_zero", {bus.mem_req.aw.lock, bus.mem_req.aw.cache, bus.mem_req.aw.prot,
                                 bus.mem_req.aw.qos, bus.mem_req.aw.region, bus.mem_req.aw.atop,
                                 bus.mem_req.aw.user}, 0);
          outstanding++;
          aw_seen = 1;
          beat = 0;
        end else begin
          aw_wait++;
        end
      end else begin
        aw_stall_prev = 0;
        aw_wait = 0;
      end

      w_cur = {bus.mem_req.w.data, bus.mem_req.w.strb, bus.mem_req.w.last};
      if (bus.mem_req.w_valid) begin
        check("w_after_aw", aw_seen, 1);
        if (w_stall_prev) check("w_stable", w_cur, w_prev);
        w_prev = w_cur;
        w_stall_prev = !wr;
        if (wr) begin
          if (beat >= 4) begin
            check("w_extra_beat", beat, 3);
          end else begin
            check("w_strb", bus.mem_req.w.strb, 8'hFF);
            check("w_last", bus.mem_req.w.last, (beat == 3));
            cap[beat*64 +: 64] = bus.mem_req.w.data;
            beat++;
            if (beat == 4) begin
              if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_data", cap, e.data);
              end else begin
                check("sb_nonempty", sb.size(), 1);
              end
              b_pend = 1;
            end
          end
        end
        w_tog = !w_tog;
      end else begin
        w_stall_prev = 0;
        w_tog = 1;
      end

      if (bus.mem_req.b_ready && bv) begin
        check("w_beats_at_b", beat, 4);
        b_pend = 0;
        outstanding--;
        aw_seen = 0;
        beat = 0;
      end
    end
  end

  // Issue one record and wait (bounded) for its completion pulse.
  task automatic send(input logic [63:0] a, input logic [255:0] d, input logic exp_err,
                      input int exp_lat, input string nm);
    int g;
    int lat;
    bit seen;
    g = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check({nm, "_ready_before"}, req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    if (a[4:0] == 5'd0) sb.push_back('{addr: a, data: d});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 500) begin
      @(negedge clk);
      lat++;
      check({nm, "_ready_low"}, req_ready, 0);
      check({nm, "_busy"}, busy, 1);
      if (a[4:0] != 5'd0) check({nm, "_no_aw"}, bus.mem_req.aw_valid, 0);
      if (done === 1'b1) seen = 1;
    end
    check({nm, "_done_seen"}, seen, 1);
    check({nm, "_error"}, error, exp_err);
    if (exp_lat > 0) check({nm, "_latency"}, lat, exp_lat);
    @(negedge clk);
    check({nm, "_done_pulse"}, done, 0);
    check({nm, "_ready_after"}, req_ready, 1);
    #1;
  endtask

  typedef struct {
    logic [63:0]  addr;
    logic [255:0] data;
    int           mode;
    logic [1:0]   resp;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  initial begin
    vec_t         vt[9];
    logic [63:0]  ra;
    logic [255:0] rd;
    logic [1:0]   rr;

    vt[0] = '{64'h0000_0000_8000_0040,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 2'b00, 1'b0, 7};
    vt[1] = '{64'h0000_0000_8000_0044, {4{64'hDEAD_BEEF_0000_0001}}, 0, 2'b00, 1'b1, 1};
    vt[2] = '{64'h0000_0000_8000_0080,
              {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003,
               64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001}, 1, 2'b00, 1'b0, 15};
    vt[3] = '{64'h0000_0000_0000_1000, {4{64'h0123_4567_89AB_CDEF}}, 0, 2'b10, 1'b1, 7};
    vt[4] = '{64'h0000_0000_0000_2020, {4{64'hFEDC_BA98_7654_3210}}, 0, 2'b11, 1'b1, 7};
    vt[5] = '{64'h0000_0000_0000_3FE0, {4{64'h5555_AAAA_5555_AAAA}}, 0, 2'b01, 1'b0, 7};
    vt[6] = '{64'h0000_0000_0000_0101, {4{64'h0}}, 0, 2'b00, 1'b1, 1};
    vt[7] = '{64'h0000_0000_0000_0010, {4{64'h1}}, 0, 2'b00, 1'b1, 1};
    vt[8] = '{64'hFFFF_FFFF_FFFF_FFE0,
              {64'hDDDD_0000_0000_0000, 64'hCCCC_0000_0000_0000,
               64'hBBBB_0000_0000_0000, 64'hAAAA_0000_0000_0000}, 0, 2'b00, 1'b0, 7};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_valids", {bus.mem_req.aw_valid, bus.mem_req.w_valid, bus.mem_req.b_ready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vt[i]) begin
      mode       = vt[i].mode;
      b_resp_cfg = vt[i].resp;
      send(vt[i].addr, vt[i].data, vt[i].exp_err, vt[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Reset after the second W handshake abandons the burst.
    mode = 0;
    b_resp_cfg = 2'b00;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 64'h0000_0000_0000_4000;
    req_data  = {4{64'h7777_0000_7777_0000}};
    sb.push_back('{addr: req_addr, data: req_data});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstmid_in_w", bus.mem_req.w_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_w_valid", bus.mem_req.w_valid, 0);
    check("rstmid_aw_valid", bus.mem_req.aw_valid, 0);
    check("rstmid_b_ready", bus.mem_req.b_ready, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", req_ready, 1);
    for (int k = 0; k < 10; k++) begin
      check("rstmid_no_done", done, 0);
      @(negedge clk);
    end
    #1;
    send(64'h0000_0000_0000_5000,
         {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
          64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101}, 1'b0, 7, "after_rst");

    // Randomised back-pressure regression.
    mode = 2;
    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) ra[4:0] = 5'd0;
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rr = 2'($urandom_range(0, 3));
      b_resp_cfg = rr;
      send(ra, rd, (ra[4:0] != 5'd0) ? 1'b1 : rr[1], 0, $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("none_outstanding", outstanding, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_iommu_fq_wr_master.md
# rv_iommu_fq_wr_master

Upstream AXI write master for the IOMMU fault-queue (FQ) port of the data-structures interface. It accepts one 32-byte fault record at a time and writes it to memory as a single 4-beat INCR burst. It then waits for the write response and reports completion and error status to the fault-queue handler. Its AXI request/response pair connects directly to the FQ port of the data-structures bus interface.

## Interface
- `axi_req_t`, `logic`: AXI full request struct; fields used are aw, aw_valid, w, w_valid, b_ready, ar_valid, r_ready.
- `axi_rsp_t`, `logic`: AXI full response struct; fields used are aw_ready, w_ready, b, b_valid.
- `AXI_ID`, `4'b0001`: AWID for all writes; must match the FQ routing ID of the interface.
- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  record write request.
- `req_ready_o`  out  1  block idle, request can be taken.
- `req_addr_i`  in  64  destination byte address; must be 32-byte aligned.
- `req_data_i`  in  256  record; bits [63:0] are beat 0, [255:192] are beat 3.
- `done_o`  out  1  one-cycle completion pulse.
- `error_o`  out  1  valid with done_o; 1 means bus error or misaligned address.
- `busy_o`  out  1  high in any state other than IDLE.
- `mem_req_o`  out  axi_req_t  AXI request towards the interface FQ port.
- `mem_resp_i`  in  axi_rsp_t  AXI response from the interface FQ port.

## Operation
- States: IDLE, AW, W, B, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch address and data and clear the beat counter.
  - If req_addr_i[4:0] is nonzero, go to DONE with the error flag set, and issue no AXI traffic. Otherwise go to AW.
- AW: aw_valid=1. Held until aw_ready, then go to W.
  - aw.id=AXI_ID, aw.addr=latched address, aw.len=3, aw.size=3 (8 B), aw.burst=INCR (2'b01).
  - aw.lock, aw.cache, aw.prot, aw.qos, aw.region, aw.atop, aw.user are all 0.
  - aw fields are stable while aw_valid is high.
- W: w_valid=1 and w.data=beat[cnt].
  - w.strb is all ones. w.last is 1 only when cnt==3.
  - On each w_ready, cnt increments (2-bit, wraps to 0 after beat 3).
  - The handshake on the last beat goes to B.
- W is never asserted before the AW handshake completes. The interface steers W using IDs queued at AW acceptance, so early W data would be routed to the wrong port.
- B: b_ready=1.
  - On b_valid, the error flag is (b.resp==SLVERR or DECERR); OKAY and EXOKAY count as success.
  - Then go to DONE.
- DONE: done_o=1 and error_o=flag for exactly one cycle, then IDLE.
- ar_valid=0 and r_ready=0 permanently; this block never reads.
- Only one transaction is outstanding at a time. A new request is accepted only in IDLE, i.e. no earlier than the cycle after done_o.
- Reset values:
  - State IDLE, cnt=0, flag=0.
  - aw_valid=w_valid=b_ready=0, done_o=error_o=busy_o=0, req_ready_o=1.
- Reset mid-burst abandons the transaction. All valids are 0 in the cycle after reset is sampled, and no done_o is produced.

## Timing
- All outputs are driven from registered state. There is no combinational path from mem_resp_i to mem_req_o valid signals.
- Request accepted at cycle 0: aw_valid is high from cycle 1.
- Zero-wait-state bus:
  - AW handshake at cycle 1.
  - W beats at cycles 2–5.
  - b_ready from cycle 6; b_valid at cycle 6 gives done_o at cycle 7.
  - Minimum latency is 7 cycles from acceptance to done_o.
  - Next acceptance is possible at cycle 8.
- Misaligned request accepted at cycle 0: done_o=1 and error_o=1 at cycle 1, with no aw_valid.
- Back-pressure: aw_valid and w_valid, once asserted, stay high with stable payload until the handshake completes (AXI rule). Each aw_ready or w_ready stall cycle adds exactly one cycle.
- b_valid arriving in the same cycle that b_ready first rises is accepted that cycle.

## Test plan
- Aligned request, addr=0x8000_0040, data beats 0x11..,0x22..,0x33..,0x44.., all readies high -> AW id=1, addr=0x8000_0040, len=3, size=3, burst=1. Four W beats in that order, strb=0xFF, last on the 4th only. done_o at cycle 7 with error_o=0.
- Misaligned addr=0x8000_0044 -> no aw_valid ever; done_o=1, error_o=1 at cycle 1; req_ready_o=1 at cycle 2.
- aw_ready low for 5 cycles, w_ready toggling 1/0 -> AW and W payloads stable during stalls, no W before the AW handshake, exactly 4 W handshakes, done_o at cycle 7+5+3.
- b.resp=SLVERR, then a second request with b.resp=DECERR, then a third with EXOKAY -> error_o=1, 1, 0 respectively. req_ready_o=0 during each transaction.
- rst_i asserted after the 2nd W handshake -> next cycle w_valid=0, busy_o=0, req_ready_o=1, no done_o. A new request afterwards completes normally with beat 0 first.
- Random back-pressure regression (1000 records) -> scoreboard matches addr/data per record, ar_valid is never 1, and there is never more than 1 outstanding AW.
